// File: rtl/div_radix2_pkg.sv
// rtl/div_radix2_pkg.sv - shared types for the execute-stage radix-2 divider
// Operation, ISA-configuration and divider FSM encodings plus the iteration count.
package div_radix2_pkg;

  typedef enum logic [1:0] {
    RV32I,
    RV32E,
    RV32M,
    RV32EM
  } rv32_e;

  typedef enum logic [4:0] {
    NOP,
    LUI,
    ADD,
    SUB,
    AND_OP,
    OR_OP,
    XOR_OP,
    SLL,
    SRL,
    SRA,
    SLT,
    SLTU,
    MUL,
    MULH,
    MULHSU,
    MULHU,
    DIV,
    DIVU,
    REM,
    REMU
  } iType_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } div_fsm;

  localparam int DIV_CYCLES = 32;

  function automatic logic is_div_op(input iType_e op);
    return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
  endfunction

  function automatic logic has_m_ext(input rv32_e cfg);
    return (cfg == RV32M) || (cfg == RV32EM);
  endfunction

endpackage

// File: rtl/div_radix2.sv
// rtl/div_radix2.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
// Stalls the pipeline for 33 cycles; zero-divisor and signed overflow resolve in the issue cycle.
module div_radix2
  import div_radix2_pkg::*;
#(
  parameter rv32_e RV32 = RV32M
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] first_operand_i,
  input  logic [31:0] second_operand_i,
  input  iType_e      instruction_operation_i,
  output logic        hold_o,
  output logic [31:0] div_result_o
);

  localparam logic M_EN = has_m_ext(RV32);

  div_fsm      state;
  div_fsm      next_state;
  iType_e      op_reg;
  logic [31:0] quot_reg;
  logic [31:0] rem_reg;
  logic [31:0] dvsr_reg;
  logic        neg_q;
  logic        neg_r;
  logic [4:0]  cnt;

  logic        div_op;
  logic        signed_op;
  logic        rem_op;
  logic        div_by_zero;
  logic        overflow;
  logic        start;
  logic [31:0] dividend_abs;
  logic [31:0] divisor_abs;
  logic [32:0] rem_shift;
  logic [32:0] trial;
  logic        reg_rem_op;

  always_comb begin
    div_op      = M_EN && is_div_op(instruction_operation_i);
    signed_op   = (instruction_operation_i == DIV) || (instruction_operation_i == REM);
    rem_op      = (instruction_operation_i == REM) || (instruction_operation_i == REMU);
    div_by_zero = (second_operand_i == 32'd0);
    overflow    = signed_op && (first_operand_i == 32'h8000_0000)
                  && (second_operand_i == 32'hFFFF_FFFF);
    start       = (state == IDLE) && div_op && !div_by_zero && !overflow;
  end

  // abs(0x80000000) wraps to itself, which is the correct unsigned magnitude
  always_comb begin
    dividend_abs = (signed_op && first_operand_i[31])  ? (32'd0 - first_operand_i)  : first_operand_i;
    divisor_abs  = (signed_op && second_operand_i[31]) ? (32'd0 - second_operand_i) : second_operand_i;
  end

  always_comb begin
    rem_shift = {rem_reg, quot_reg[31]};
    trial     = rem_shift - {1'b0, dvsr_reg};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? CALC : IDLE;
      CALC:    next_state = (cnt == 5'd0) ? FINISH : CALC;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg   <= NOP;
      quot_reg <= 32'd0;
      rem_reg  <= 32'd0;
      dvsr_reg <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      cnt      <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_reg   <= instruction_operation_i;
            quot_reg <= dividend_abs;
            dvsr_reg <= divisor_abs;
            rem_reg  <= 32'd0;
            neg_q    <= signed_op && (first_operand_i[31] ^ second_operand_i[31]);
            neg_r    <= signed_op && first_operand_i[31];
            cnt      <= 5'(DIV_CYCLES - 1);
          end
        end
        CALC: begin
          if (!trial[32]) begin
            rem_reg  <= trial[31:0];
            quot_reg <= {quot_reg[30:0], 1'b1};
          end else begin
            rem_reg  <= rem_shift[31:0];
            quot_reg <= {quot_reg[30:0], 1'b0};
          end
          cnt <= cnt - 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    reg_rem_op = (op_reg == REM) || (op_reg == REMU);
  end

  always_comb begin
    hold_o       = 1'b0;
    div_result_o = 32'd0;
    case (state)
      IDLE: begin
        if (div_op) begin
          if (div_by_zero) begin
            div_result_o = rem_op ? first_operand_i : 32'hFFFF_FFFF;
          end else if (overflow) begin
            div_result_o = rem_op ? 32'd0 : 32'h8000_0000;
          end else begin
            hold_o = 1'b1;
          end
        end
      end
      CALC: hold_o = 1'b1;
      FINISH: begin
        if (reg_rem_op) begin
          div_result_o = neg_r ? (32'd0 - rem_reg) : rem_reg;
        end else begin
          div_result_o = neg_q ? (32'd0 - quot_reg) : quot_reg;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_div_radix2.sv
// tb/tb_div_radix2.sv - scoreboard bench for div_radix2 against an arithmetic reference
module tb_div_radix2;
  import div_radix2_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  iType_e      op = NOP;
  logic        hold;
  logic [31:0] res;

  typedef struct {
    logic [31:0] res;
    int          stalls;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   hcnt = 0;

  iType_e ops[8] = '{DIV, DIVU, REM, REMU, ADD, NOP, MUL, SUB};

  div_radix2 dut (
    .clk                     (clk),
    .reset                   (reset),
    .first_operand_i         (a),
    .second_operand_i        (b),
    .instruction_operation_i (op),
    .hold_o                  (hold),
    .div_result_o            (res)
  );

  always #5 clk = ~clk;

  function automatic logic is_ovf(input iType_e o, input logic [31:0] x, input logic [31:0] y);
    return ((o == DIV) || (o == REM)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(input iType_e o, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    logic signed [31:0] sr;
    sx = x;
    sy = y;
    case (o)
      DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      REMU: return (y == 0) ? x : x % y;
      DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (is_ovf(o, x, y)) return 32'h8000_0000;
        sr = sx / sy;
        return sr;
      end
      REM: begin
        if (y == 0) return x;
        if (is_ovf(o, x, y)) return 32'd0;
        sr = sx % sy;
        return sr;
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_stalls(input iType_e o, input logic [31:0] x, input logic [31:0] y);
    if (!is_div_op(o) || (y == 0) || is_ovf(o, x, y)) return 0;
    return 33;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input iType_e o, input logic [31:0] x, input logic [31:0] y, input string name);
    exp_t e;
    bit   done;
    @(posedge clk);
    #1;
    op = o;
    a  = x;
    b  = y;
    e.res    = ref_result(o, x, y);
    e.stalls = ref_stalls(o, x, y);
    e.name   = name;
    sb.push_back(e);
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
      // inputs are scrambled while the divider iterates; the result must not change
      op = ops[$urandom_range(0, 7)];
      a  = $urandom;
      b  = $urandom;
    end
    op = NOP;
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL %s: no result within bound, queue depth %0d required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        if (hold) begin
          hcnt++;
          if (hcnt > 40) begin
            compared++;
            mismatched++;
            $display("FAIL %s_stall: hold stuck high for %0d cycles, required %0d", sb[0].name, hcnt, sb[0].stalls);
            void'(sb.pop_front());
            hcnt = 0;
          end
        end else begin
          compared++;
          if (res !== sb[0].res) begin
            mismatched++;
            $display("FAIL %s_result: got %08h required %08h", sb[0].name, res, sb[0].res);
          end
          compared++;
          if (hcnt != sb[0].stalls) begin
            mismatched++;
            $display("FAIL %s_stalls: got %0d required %0d", sb[0].name, hcnt, sb[0].stalls);
          end
          void'(sb.pop_front());
          hcnt = 0;
        end
      end
    end
  end

  initial begin
    exp_t e;
    iType_e ro;
    repeat (3) @(posedge clk);
    #1;
    e.res = 32'd0; e.stalls = 0; e.name = "reset_state";
    sb.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b0;

    issue(DIVU, 32'd100, 32'd7, "divu_100_7");
    issue(REMU, 32'd100, 32'd7, "remu_100_7");
    issue(DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    issue(REM, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    issue(REM, 32'd7, 32'hFFFF_FFFE, "rem_7_m2");
    issue(DIVU, 32'h1234_5678, 32'd0, "divu_by0");
    issue(REM, 32'd5, 32'd0, "rem_by0");
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    issue(REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    issue(DIVU, 32'd100, 32'd7, "divu_after_fast");
    issue(ADD, 32'd9, 32'd3, "add_idle");
    issue(DIV, 32'h8000_0000, 32'd1, "div_minint_1");
    issue(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, "divu_minint");

    // abort a long division with reset partway through CALC
    @(posedge clk);
    #1;
    op = DIVU; a = 32'hFFFF_FFFF; b = 32'd1;
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    op = NOP;
    @(posedge clk);
    #1;
    e.res = 32'd0; e.stalls = 0; e.name = "reset_abort";
    sb.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue(DIVU, 32'hFFFF_FFFF, 32'd1, "divu_reissue");

    for (int i = 0; i < 50; i++) begin
      ro = ops[$urandom_range(0, 4)];
      issue(ro, rnd_val(), rnd_val(), $sformatf("rand%0d", i));
    end

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
